// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - request/response bus between the issue logic and the alu sequencer
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             req;
  logic [3:0]       op;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             cin;
  logic             abort;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] res_do;
  logic [3:0]       res_flags;

  modport master (
    output req, op, opa, opb, cin, abort,
    input  ready, done, result, res_do, res_flags
  );

  modport slave (
    input  req, op, opa, opb, cin, abort,
    output ready, done, result, res_do, res_flags
  );
endinterface

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequencer driving one combinational alu from registers
// Single-cycle ops take one execute cycle; INST 6 loops ITER passes with registered DO->DI feedback.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32,
  parameter int CW    = 6
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  alu_seq_if.slave         bus,
  output logic [3:0]       o_alu_inst,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  output logic [WIDTH-1:0] o_alu_di,
  output logic             o_alu_ci,
  output logic             o_alu_fc,
  input  logic [WIDTH-1:0] i_alu_z,
  input  logic [WIDTH-1:0] i_alu_do,
  input  logic [3:0]       i_alu_flags
);

  localparam logic [1:0]    S_IDLE    = 2'd0;
  localparam logic [1:0]    S_EXEC    = 2'd1;
  localparam logic [1:0]    S_DIVI    = 2'd2;
  localparam logic [1:0]    S_FIN     = 2'd3;
  localparam logic [3:0]    OP_DIVI   = 4'd6;
  localparam logic [CW-1:0] LAST_PASS = CW'(ITER - 1);

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [3:0]       r_inst;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_di;
  logic             r_ci;
  logic             r_fc;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_res_do;
  logic [3:0]       r_res_flags;
  logic             w_last_pass;

  assign w_last_pass = (r_cnt == LAST_PASS);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_inst      <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_di        <= '0;
      r_ci        <= 1'b0;
      r_fc        <= 1'b0;
      r_result    <= '0;
      r_res_do    <= '0;
      r_res_flags <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // abort is deliberately ignored here so a colliding request still starts
          if (bus.req) begin
            r_inst <= bus.op;
            r_a    <= bus.opa;
            r_b    <= bus.opb;
            r_ci   <= bus.cin;
            r_di   <= '0;
            r_cnt  <= '0;
            if (bus.op == OP_DIVI) begin
              r_fc    <= 1'b1;
              r_state <= S_DIVI;
            end else begin
              r_fc    <= 1'b0;
              r_state <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          if (bus.abort) begin
            r_state <= S_IDLE;
          end else begin
            r_result    <= i_alu_z;
            r_res_do    <= i_alu_do;
            r_res_flags <= i_alu_flags;
            r_state     <= S_FIN;
          end
        end
        S_DIVI: begin
          r_fc <= 1'b0;
          if (bus.abort) begin
            r_state <= S_IDLE;
          end else if (w_last_pass) begin
            r_result    <= i_alu_z;
            r_res_do    <= i_alu_do;
            r_res_flags <= i_alu_flags;
            r_state     <= S_FIN;
          end else begin
            // feedback is registered so the alu never sees a combinational loop
            r_b   <= i_alu_z;
            r_di  <= i_alu_do;
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ready     = (r_state == S_IDLE);
  assign bus.done      = (r_state == S_FIN);
  assign bus.result    = r_result;
  assign bus.res_do    = r_res_do;
  assign bus.res_flags = r_res_flags;

  assign o_alu_inst = r_inst;
  assign o_alu_a    = r_a;
  assign o_alu_b    = r_b;
  assign o_alu_di   = r_di;
  assign o_alu_ci   = r_ci;
  assign o_alu_fc   = r_fc;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed bench for alu_seq with a stub alu
module tb_alu_seq;
  localparam int W    = 32;
  localparam int ITER = 32;
  localparam int CW   = 6;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [3:0]   alu_inst;
  logic [W-1:0] alu_a, alu_b, alu_di, alu_z, alu_do;
  logic         alu_ci, alu_fc;
  logic [3:0]   alu_flags;

  int n_cmp = 0;
  int n_bad = 0;
  int n;
  logic [W-1:0] div_result;

  alu_seq_if #(.WIDTH(W)) bus_if ();

  alu_seq #(.WIDTH(W), .ITER(ITER), .CW(CW)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .bus         (bus_if.slave),
    .o_alu_inst  (alu_inst),
    .o_alu_a     (alu_a),
    .o_alu_b     (alu_b),
    .o_alu_di    (alu_di),
    .o_alu_ci    (alu_ci),
    .o_alu_fc    (alu_fc),
    .i_alu_z     (alu_z),
    .i_alu_do    (alu_do),
    .i_alu_flags (alu_flags)
  );

  always #5 clk = ~clk;

  // stub alu: returns {flags, do, z}; flags = {ovf, carry, zero, rsvd}
  function automatic logic [4+2*W-1:0] stub_alu(input logic [3:0] inst, input logic [W-1:0] a,
      input logic [W-1:0] b, input logic [W-1:0] di, input logic ci, input logic fc);
    logic [W:0]   sum;
    logic [W-1:0] z, d;
    logic [3:0]   f;
    d = '0;
    case (inst)
      4'd2: begin
        sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        z   = sum[W-1:0];
        f   = {(a[W-1] == b[W-1]) && (z[W-1] != a[W-1]), sum[W], z == '0, 1'b0};
      end
      4'd6: begin
        z = {b[W-2:0], di[W-1]} ^ a ^ {{(W-1){1'b0}}, fc};
        d = {di[W-2:0], z[0]};
        f = {2'b00, z == '0, 1'b0};
      end
      4'd12: begin z = a; f = {2'b00, z == '0, 1'b0}; end
      4'd15: begin z = b; f = {2'b00, z == '0, 1'b0}; end
      default: begin z = a ^ b; f = {2'b00, z == '0, 1'b0}; end
    endcase
    return {f, d, z};
  endfunction

  always_comb {alu_flags, alu_do, alu_z} = stub_alu(alu_inst, alu_a, alu_b, alu_di, alu_ci, alu_fc);

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    bus_if.req = 1'b1; bus_if.op = op; bus_if.opa = a; bus_if.opb = b; bus_if.cin = ci;
    @(negedge clk);
    bus_if.req = 1'b0;
  endtask

  task automatic wait_done(input int max, output int cnt);
    cnt = 0;
    while (!bus_if.done && cnt < max) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus_if.ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", bus_if.ready); end
    n_cmp++; if (bus_if.done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", bus_if.done); end
    n_cmp++; if ({bus_if.result, bus_if.res_do, bus_if.res_flags} !== '0) begin n_bad++; $display("FAIL reset_results: got %h %h %h want 0", bus_if.result, bus_if.res_do, bus_if.res_flags); end
    n_cmp++; if ({alu_inst, alu_a, alu_b, alu_di, alu_ci, alu_fc} !== '0) begin n_bad++; $display("FAIL reset_alu_outs: got %h %h %h %h %b %b want 0", alu_inst, alu_a, alu_b, alu_di, alu_ci, alu_fc); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_midop;
    issue(4'd6, 32'h3, 32'h7, 1'b0);
    repeat (5) @(negedge clk);
    n_cmp++; if (alu_fc !== 1'b0 || alu_inst !== 4'd6) begin n_bad++; $display("FAIL midop_running: got fc=%b inst=%h want fc=0 inst=6", alu_fc, alu_inst); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus_if.ready !== 1'b1) begin n_bad++; $display("FAIL midop_ready: got %b want 1", bus_if.ready); end
    n_cmp++; if ({bus_if.result, bus_if.res_do, bus_if.res_flags, bus_if.done} !== '0) begin n_bad++; $display("FAIL midop_results: got %h %h %h %b want 0", bus_if.result, bus_if.res_do, bus_if.res_flags, bus_if.done); end
    n_cmp++; if ({alu_inst, alu_a, alu_b, alu_di, alu_ci, alu_fc} !== '0) begin n_bad++; $display("FAIL midop_alu_outs: got %h %h %h %h %b %b want 0", alu_inst, alu_a, alu_b, alu_di, alu_ci, alu_fc); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++; if (bus_if.done !== 1'b0 || bus_if.ready !== 1'b1) begin n_bad++; $display("FAIL midop_quiet[%0d]: got done=%b ready=%b want 0/1", i, bus_if.done, bus_if.ready); end
    end
  endtask

  task automatic test_add;
    @(negedge clk);
    issue(4'd2, 32'h1, 32'h1, 1'b0);
    n_cmp++; if (bus_if.ready !== 1'b0) begin n_bad++; $display("FAIL add_busy: got ready=%b want 0", bus_if.ready); end
    wait_done(10, n);
    n_cmp++; if (n !== 1) begin n_bad++; $display("FAIL add_latency: got %0d want 1", n); end
    n_cmp++; if (bus_if.result !== 32'h2) begin n_bad++; $display("FAIL add_result: got %h want 00000002", bus_if.result); end
    n_cmp++; if (bus_if.res_flags !== 4'h0) begin n_bad++; $display("FAIL add_flags: got %h want 0", bus_if.res_flags); end
    @(negedge clk);
    n_cmp++; if (bus_if.done !== 1'b0 || bus_if.ready !== 1'b1) begin n_bad++; $display("FAIL add_pulse: got done=%b ready=%b want 0/1", bus_if.done, bus_if.ready); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    issue(4'd2, 32'hFFFF_FFFF, 32'h1, 1'b0);
    wait_done(10, n);
    n_cmp++; if (bus_if.result !== 32'h0) begin n_bad++; $display("FAIL wrap_result: got %h want 00000000", bus_if.result); end
    n_cmp++; if (bus_if.res_flags !== 4'h6) begin n_bad++; $display("FAIL wrap_flags: got %h want 6", bus_if.res_flags); end
    @(negedge clk);
    n_cmp++; if (bus_if.ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready: got %b want 1", bus_if.ready); end
    issue(4'd15, 32'h0, 32'h1, 1'b0);
    wait_done(10, n);
    n_cmp++; if (n !== 1) begin n_bad++; $display("FAIL b2b_latency: got %0d want 1", n); end
    n_cmp++; if (bus_if.result !== 32'h1) begin n_bad++; $display("FAIL b2b_result: got %h want 00000001", bus_if.result); end
  endtask

  task automatic test_division;
    logic [W-1:0] mb, mdi, ez, ed;
    logic [3:0]   ef;
    logic         mfc;
    int           pass_err;
    mb = 32'h7; mdi = '0; mfc = 1'b1; ez = '0; ed = '0; ef = '0; pass_err = 0;
    @(negedge clk);
    issue(4'd6, 32'h3, 32'h7, 1'b0);
    for (int p = 0; p < ITER; p++) begin
      n_cmp++;
      if (alu_fc !== mfc || alu_b !== mb || alu_di !== mdi || alu_a !== 32'h3 || bus_if.done !== 1'b0) begin
        n_bad++; pass_err++;
        $display("FAIL div_pass[%0d]: got fc=%b b=%h di=%h a=%h done=%b want fc=%b b=%h di=%h a=00000003 done=0", p, alu_fc, alu_b, alu_di, alu_a, bus_if.done, mfc, mb, mdi);
      end
      {ef, ed, ez} = stub_alu(4'd6, 32'h3, mb, mdi, 1'b0, mfc);
      mb = ez; mdi = ed; mfc = 1'b0;
      @(negedge clk);
    end
    n_cmp++; if (bus_if.done !== 1'b1) begin n_bad++; $display("FAIL div_done_after_%0d_passes: got %b want 1", ITER, bus_if.done); end
    n_cmp++; if (bus_if.result !== ez || bus_if.res_do !== ed || bus_if.res_flags !== ef) begin n_bad++; $display("FAIL div_result: got %h %h %h want %h %h %h", bus_if.result, bus_if.res_do, bus_if.res_flags, ez, ed, ef); end
    div_result = ez;
  endtask

  task automatic test_busy_abort;
    @(negedge clk);
    issue(4'd6, 32'h3, 32'h7, 1'b0);
    for (int p = 0; p < 10; p++) begin
      bus_if.req = 1'b1; bus_if.op = 4'd8; bus_if.opa = 32'h1234; bus_if.opb = 32'h5678;
      @(negedge clk);
      n_cmp++; if (bus_if.ready !== 1'b0 || alu_inst !== 4'd6 || alu_a !== 32'h3 || bus_if.done !== 1'b0) begin n_bad++; $display("FAIL busy_ignore[%0d]: got ready=%b inst=%h a=%h done=%b want 0/6/3/0", p, bus_if.ready, alu_inst, alu_a, bus_if.done); end
    end
    bus_if.req = 1'b0; bus_if.abort = 1'b1;
    @(negedge clk);
    bus_if.abort = 1'b0;
    n_cmp++; if (bus_if.ready !== 1'b1 || bus_if.done !== 1'b0) begin n_bad++; $display("FAIL abort_div_state: got ready=%b done=%b want 1/0", bus_if.ready, bus_if.done); end
    n_cmp++; if (bus_if.result !== div_result) begin n_bad++; $display("FAIL abort_div_result: got %h want %h", bus_if.result, div_result); end
    @(negedge clk);
    n_cmp++; if (bus_if.done !== 1'b0) begin n_bad++; $display("FAIL abort_div_nodone: got %b want 0", bus_if.done); end
  endtask

  task automatic test_exec_abort;
    @(negedge clk);
    issue(4'd2, 32'h5, 32'h5, 1'b0);
    bus_if.abort = 1'b1;
    @(negedge clk);
    bus_if.abort = 1'b0;
    n_cmp++; if (bus_if.ready !== 1'b1 || bus_if.done !== 1'b0 || bus_if.result !== div_result) begin n_bad++; $display("FAIL abort_exec: got ready=%b done=%b result=%h want 1/0/%h", bus_if.ready, bus_if.done, bus_if.result, div_result); end
  endtask

  task automatic test_abort_fin;
    @(negedge clk);
    issue(4'd12, 32'hA5A5_A5A5, 32'h0, 1'b0);
    @(negedge clk);
    bus_if.abort = 1'b1;
    #1;
    n_cmp++; if (bus_if.done !== 1'b1 || bus_if.result !== 32'hA5A5_A5A5) begin n_bad++; $display("FAIL abort_fin: got done=%b result=%h want 1/a5a5a5a5", bus_if.done, bus_if.result); end
    @(negedge clk);
    n_cmp++; if (bus_if.ready !== 1'b1 || bus_if.result !== 32'hA5A5_A5A5) begin n_bad++; $display("FAIL abort_fin_idle: got ready=%b result=%h want 1/a5a5a5a5", bus_if.ready, bus_if.result); end
    issue(4'd15, 32'h0, 32'h9, 1'b0);
    bus_if.abort = 1'b0;
    n_cmp++; if (bus_if.ready !== 1'b0) begin n_bad++; $display("FAIL req_abort_accept: got ready=%b want 0", bus_if.ready); end
    wait_done(10, n);
    n_cmp++; if (n !== 1 || bus_if.result !== 32'h9) begin n_bad++; $display("FAIL req_abort_result: got n=%0d result=%h want 1/00000009", n, bus_if.result); end
  endtask

  initial begin
    bus_if.req = 1'b0; bus_if.op = '0; bus_if.opa = '0; bus_if.opb = '0;
    bus_if.cin = 1'b0; bus_if.abort = 1'b0; div_result = '0;
    test_reset;
    test_reset_midop;
    test_add;
    test_back_to_back;
    test_division;
    test_busy_abort;
    test_exec_abort;
    test_abort_fin;
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
